// File: rtl/display_frame_reader.sv
// -----------------------------------------------------------------------------
// display_frame_reader
//
// Framebuffer fetch client for the two-port memory resource controller.
// Reads a linear framebuffer region in bursts of P_BURST words, buffers the
// returned data in a first-word-fall-through FIFO and streams it to the display
// pipeline together with a frame-start marker on word 0 of every frame.
//
// A burst is only requested when the FIFO already has room for the whole
// burst. That space is effectively reserved, so the read-data path never
// needs to back-pressure the controller.
//
// Ports
//   iCLOCK, inRESET         clock, asynchronous active-low reset
//   iRESET_SYNC             synchronous reset shared with the controller
//   iENA                    fetch enable (level)
//   oARBIT_REQ / iARBIT_ACK / oARBIT_FINISH
//                           memory-port arbitration handshake
//   oMEM_ENA, oMEM_RW, oMEM_ADDR, oMEM_DATA, iMEM_BUSY
//                           read command channel (oMEM_RW/oMEM_DATA tied to 0)
//   iMEM_VALID, iMEM_DATA, oMEM_BUSY
//                           read return channel (oMEM_BUSY tied to 0)
//   oPIX_VALID, iPIX_BUSY, oPIX_DATA, oPIX_FRAME_START
//                           output stream, FWFT valid/busy
// -----------------------------------------------------------------------------
module display_frame_reader #(
  parameter int unsigned                  P_MEM_ADDR_N   = 22,
  parameter logic [P_MEM_ADDR_N-1:0]      P_FB_BASE      = 22'h000000,
  parameter int unsigned                  P_FB_WORDS     = 19200,
  parameter int unsigned                  P_BURST        = 16,
  parameter int unsigned                  P_FIFO_DEPTH_N = 5
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iENA,
  output logic                    oARBIT_REQ,
  input  logic                    iARBIT_ACK,
  output logic                    oARBIT_FINISH,
  output logic                    oMEM_ENA,
  input  logic                    iMEM_BUSY,
  output logic                    oMEM_RW,
  output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
  output logic [31:0]             oMEM_DATA,
  input  logic                    iMEM_VALID,
  output logic                    oMEM_BUSY,
  input  logic [31:0]             iMEM_DATA,
  output logic                    oPIX_VALID,
  input  logic                    iPIX_BUSY,
  output logic [31:0]             oPIX_DATA,
  output logic                    oPIX_FRAME_START
);

  localparam int unsigned DEPTH = 1 << P_FIFO_DEPTH_N;
  localparam int unsigned CNT_W = $clog2(P_BURST + 1);
  localparam int unsigned FCW   = P_FIFO_DEPTH_N + 1;

  localparam logic [P_MEM_ADDR_N-1:0]   LAST_ADDR  = P_FB_BASE + P_MEM_ADDR_N'(P_FB_WORDS - 1);
  localparam logic [CNT_W-1:0]          BURST_CNT  = CNT_W'(P_BURST);
  localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);
  localparam logic [FCW-1:0]            FIFO_CAP   = FCW'(DEPTH);
  localparam logic [FCW-1:0]            BURST_FREE = FCW'(P_BURST);
  localparam logic [FCW-1:0]            FCNT_ONE   = FCW'(1);
  localparam logic [P_FIFO_DEPTH_N-1:0] IDX_ONE    = P_FIFO_DEPTH_N'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CMD,
    ST_DRAIN,
    ST_FIN
  } state_t;

  // FIFO entry: {frame_flag, data}
  typedef struct packed {
    logic        frame;
    logic [31:0] data;
  } entry_t;

  state_t                    state_q,    state_d;
  logic [P_MEM_ADDR_N-1:0]   ptr_q,      ptr_d;      // next address to issue
  logic [P_MEM_ADDR_N-1:0]   ret_ptr_q,  ret_ptr_d;  // address of next returned word
  logic [CNT_W-1:0]          issued_q,   issued_d;
  logic [CNT_W-1:0]          returned_q, returned_d;
  logic [FCW-1:0]            count_q,    count_d;
  logic [P_FIFO_DEPTH_N-1:0] wr_idx_q,   wr_idx_d;
  logic [P_FIFO_DEPTH_N-1:0] rd_idx_q,   rd_idx_d;

  entry_t mem_q [DEPTH];

  logic           issue;
  logic           push;
  logic           pop;
  logic [FCW-1:0] free_entries;
  entry_t         head;

  // Linear advance through the framebuffer, wrapping after the last word.
  function automatic logic [P_MEM_ADDR_N-1:0] next_addr(input logic [P_MEM_ADDR_N-1:0] a);
    return (a == LAST_ADDR) ? P_FB_BASE : a + P_MEM_ADDR_N'(1);
  endfunction

  assign free_entries = FIFO_CAP - count_q;
  assign head         = mem_q[rd_idx_q];

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned; that is what keeps this purely combinational.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ret_ptr_d  = ret_ptr_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    count_d    = count_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    issue      = 1'b0;
    push       = iMEM_VALID && (state_q == ST_CMD || state_q == ST_DRAIN);
    pop        = (count_q != '0) && !iPIX_BUSY;

    unique case (state_q)
      ST_IDLE: begin
        if (iENA && free_entries >= BURST_FREE) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (iARBIT_ACK) state_d = ST_CMD;
      end
      ST_CMD: begin
        // issued never reaches P_BURST here: the last issue leaves for DRAIN.
        if (!iMEM_BUSY) begin
          issue    = 1'b1;
          ptr_d    = next_addr(ptr_q);
          issued_d = issued_q + CNT_ONE;
          if (issued_q == BURST_CNT - CNT_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (returned_q == BURST_CNT) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d    = ST_IDLE;
        issued_d   = '0;
        returned_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Returns are in order, so a return-side address counter reproduces the
    // address each word was fetched from and hence its frame-start flag.
    if (push) begin
      returned_d = returned_q + CNT_ONE;
      ret_ptr_d  = next_addr(ret_ptr_q);
      wr_idx_d   = wr_idx_q + IDX_ONE;
    end
    if (pop) rd_idx_d = rd_idx_q + IDX_ONE;

    unique case ({push, pop})
      2'b10:   count_d = count_q + FCNT_ONE;
      2'b01:   count_d = count_q - FCNT_ONE;
      default: count_d = count_q;
    endcase

    // The shared synchronous reset overrides everything above. No FINISH is
    // sent: the controller is reset by the same signal.
    if (iRESET_SYNC) begin
      state_d    = ST_IDLE;
      ptr_d      = P_FB_BASE;
      ret_ptr_d  = P_FB_BASE;
      issued_d   = '0;
      returned_d = '0;
      count_d    = '0;
      wr_idx_d   = '0;
      rd_idx_d   = '0;
      issue      = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= ST_IDLE;
      ptr_q      <= P_FB_BASE;
      ret_ptr_q  <= P_FB_BASE;
      issued_q   <= '0;
      returned_q <= '0;
      count_q    <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ret_ptr_q  <= ret_ptr_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      count_q    <= count_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through the count/pointer logic, which is reset, and the output is
  // forced to zero while the FIFO is empty.
  always_ff @(posedge iCLOCK) begin
    if (push) mem_q[wr_idx_q] <= '{frame: (ret_ptr_q == P_FB_BASE), data: iMEM_DATA};
  end

  // Outputs are held at zero during the synchronous reset cycle as well.
  assign oARBIT_REQ       = (state_q == ST_REQ) && !iRESET_SYNC;
  assign oARBIT_FINISH    = (state_q == ST_FIN) && !iRESET_SYNC;
  assign oMEM_ENA         = issue;
  assign oMEM_ADDR        = issue ? ptr_q : '0;
  assign oMEM_RW          = 1'b0;
  assign oMEM_DATA        = '0;
  assign oMEM_BUSY        = 1'b0;
  assign oPIX_VALID       = (count_q != '0) && !iRESET_SYNC;
  assign oPIX_DATA        = oPIX_VALID ? head.data : 32'h0;
  assign oPIX_FRAME_START = oPIX_VALID && head.frame;

endmodule

// File: tb/tb_display_frame_reader.sv
// -----------------------------------------------------------------------------
// Testbench for display_frame_reader.
// An environment process models the arbiter and the memory controller
// (in-order read returns after a programmable latency). Every accepted read
// command is checked against a reference address sequence and pushes the
// expected output word into a scoreboard queue; a separate monitor pops and
// compares whenever the DUT hands a word to the consumer.
// -----------------------------------------------------------------------------
module tb_display_frame_reader;

  localparam int          AW    = 22;
  localparam int          BURST = 16;
  localparam int          FBW   = 32;
  localparam logic [21:0] BASE  = 22'h000000;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iENA = 1'b0;
  logic        iARBIT_ACK = 1'b0;
  logic        iMEM_BUSY = 1'b0;
  logic        iMEM_VALID = 1'b0;
  logic [31:0] iMEM_DATA = 32'h0;
  logic        iPIX_BUSY = 1'b0;

  logic          oARBIT_REQ, oARBIT_FINISH, oMEM_ENA, oMEM_RW, oMEM_BUSY;
  logic [AW-1:0] oMEM_ADDR;
  logic [31:0]   oMEM_DATA, oPIX_DATA;
  logic          oPIX_VALID, oPIX_FRAME_START;

  display_frame_reader #(
    .P_MEM_ADDR_N  (AW),
    .P_FB_BASE     (BASE),
    .P_FB_WORDS    (FBW),
    .P_BURST       (BURST),
    .P_FIFO_DEPTH_N(5)
  ) dut (
    .iCLOCK          (iCLOCK),
    .inRESET         (inRESET),
    .iRESET_SYNC     (iRESET_SYNC),
    .iENA            (iENA),
    .oARBIT_REQ      (oARBIT_REQ),
    .iARBIT_ACK      (iARBIT_ACK),
    .oARBIT_FINISH   (oARBIT_FINISH),
    .oMEM_ENA        (oMEM_ENA),
    .iMEM_BUSY       (iMEM_BUSY),
    .oMEM_RW         (oMEM_RW),
    .oMEM_ADDR       (oMEM_ADDR),
    .oMEM_DATA       (oMEM_DATA),
    .iMEM_VALID      (iMEM_VALID),
    .oMEM_BUSY       (oMEM_BUSY),
    .iMEM_DATA       (iMEM_DATA),
    .oPIX_VALID      (oPIX_VALID),
    .iPIX_BUSY       (iPIX_BUSY),
    .oPIX_DATA       (oPIX_DATA),
    .oPIX_FRAME_START(oPIX_FRAME_START)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct { logic [31:0] data; logic fs; } exp_t;
  typedef struct { int due; logic [21:0] addr; } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Environment knobs (written by the main sequence).
  int lat       = 2;   // read latency in cycles
  int ack_delay = 2;   // grant delay after REQ is first seen
  int busy_mode = 0;   // 0 never, 1 toggle, 2 random
  int pix_mode  = 0;   // 0 never busy, 1 always busy, 2 random, 3 pop limit
  int pop_limit = 0;

  // Environment / reference-model state.
  int          cyc = 0;
  int          last_due = 0;
  logic        ack_sched = 1'b0;
  int          ack_at = 0;
  logic        in_burst = 1'b0;
  int          b_issued = 0;
  int          b_returned = 0;
  int          fin_cnt = 0;
  int          cmd_cnt = 0;
  int          req_rises = 0;
  int          pop_cnt = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_fin = 1'b0;
  logic [21:0] exp_addr = BASE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    return {a[9:0], a} ^ 32'hA5C3_0F00;
  endfunction

  function automatic logic [21:0] model_next(input logic [21:0] a);
    return (a == BASE + 22'(FBW - 1)) ? BASE : a + 22'd1;
  endfunction

  // Arbiter + memory controller model, plus command-side checks.
  initial begin
    forever begin
      @(posedge iCLOCK); #1;
      cyc++;
      iARBIT_ACK = ack_sched && (cyc == ack_at);
      if (iARBIT_ACK) begin
        ack_sched  = 1'b0;
        in_burst   = 1'b1;
        b_issued   = 0;
        b_returned = 0;
      end
      iMEM_VALID = 1'b0;
      iMEM_DATA  = 32'h0;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        iMEM_VALID = 1'b1;
        iMEM_DATA  = mem_word(ret_q[0].addr);
        void'(ret_q.pop_front());
        if (in_burst) b_returned++;
      end
      case (busy_mode)
        0:       iMEM_BUSY = 1'b0;
        1:       iMEM_BUSY = cyc[0];
        default: iMEM_BUSY = 1'($urandom_range(0, 1));
      endcase
      case (pix_mode)
        0:       iPIX_BUSY = 1'b0;
        1:       iPIX_BUSY = 1'b1;
        2:       iPIX_BUSY = ($urandom_range(0, 3) == 0);
        default: iPIX_BUSY = (pop_cnt >= pop_limit);
      endcase

      @(negedge iCLOCK);
      if (inRESET) begin
        if (oMEM_ENA) begin
          check("ena_while_busy", iMEM_BUSY, 0);
          check("ena_in_grant", in_burst, 1);
          check("burst_cmd_limit", b_issued < BURST, 1);
          check("cmd_addr", oMEM_ADDR, exp_addr);
          exp_q.push_back('{data: mem_word(exp_addr), fs: (exp_addr == BASE)});
          exp_addr = model_next(exp_addr);
          b_issued++;
          cmd_cnt++;
          last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          ret_q.push_back('{due: last_due, addr: oMEM_ADDR});
        end
        if (prev_req && !prev_ack) check("req_held", oARBIT_REQ, 1);
        if (prev_ack) check("req_drop_after_ack", oARBIT_REQ, 0);
        if (oARBIT_REQ && !prev_req) begin
          req_rises++;
          check("req_gap_after_fin", prev_fin, 0);
        end
        if (oARBIT_REQ && !ack_sched && !in_burst) begin
          ack_sched = 1'b1;
          ack_at    = cyc + ack_delay;
        end
        if (oARBIT_FINISH) begin
          check("fin_single", prev_fin, 0);
          check("fin_in_grant", in_burst, 1);
          check("fin_cmds", b_issued, BURST);
          check("fin_returns", b_returned, BURST);
          fin_cnt++;
          in_burst = 1'b0;
        end
        prev_req = oARBIT_REQ;
        prev_ack = iARBIT_ACK;
        prev_fin = oARBIT_FINISH;
      end
    end
  end

  // Output monitor: compares each accepted word against the scoreboard.
  initial begin
    forever begin
      @(negedge iCLOCK);
      if (inRESET && oPIX_VALID && !iPIX_BUSY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pix_unexpected: got word 0x%0h, expected no word (t=%0t)", oPIX_DATA, $time);
        end else begin
          check("pix_data", oPIX_DATA, exp_q[0].data);
          check("pix_frame_start", oPIX_FRAME_START, exp_q[0].fs);
          void'(exp_q.pop_front());
        end
        pop_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge iCLOCK); #2;
  endtask

  task automatic wait_fin(input int target, input int budget);
    int n = 0;
    while (fin_cnt < target && n < budget) begin
      @(negedge iCLOCK); #1;
      n++;
    end
    if (fin_cnt < target) check("timeout_fin", fin_cnt, target);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    pix_mode = 0;
    while ((exp_q.size() != 0 || ret_q.size() != 0) && n < budget) begin
      @(negedge iCLOCK); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"},    oARBIT_REQ, 0);
    check({tag, "_fin"},    oARBIT_FINISH, 0);
    check({tag, "_ena"},    oMEM_ENA, 0);
    check({tag, "_addr"},   oMEM_ADDR, 0);
    check({tag, "_pvalid"}, oPIX_VALID, 0);
    check({tag, "_pdata"},  oPIX_DATA, 0);
    check({tag, "_pfs"},    oPIX_FRAME_START, 0);
  endtask

  initial begin
    int f0;
    int r0;
    int n;

    // Asynchronous reset.
    repeat (3) @(negedge iCLOCK);
    check_outputs_zero("reset");
    check("reset_rw", oMEM_RW, 0);
    check("reset_mdata", oMEM_DATA, 0);
    check("reset_mbusy", oMEM_BUSY, 0);
    step();
    inRESET = 1'b1;
    repeat (2) step();

    // Single burst: ACK after 2 cycles, no busy, 2-cycle latency.
    iENA = 1'b1;
    wait_fin(1, 300);
    step();
    iENA = 1'b0;
    wait_drain(200);
    check("burst1_cmds", cmd_cnt, 16);
    check("burst1_pops", pop_cnt, 16);

    // Command channel busy toggling every cycle.
    busy_mode = 1;
    step();
    iENA = 1'b1;
    wait_fin(2, 400);
    step();
    iENA = 1'b0;
    busy_mode = 0;
    wait_drain(200);
    check("burst2_cmds", cmd_cnt, 32);

    // Consumer stalled: exactly two bursts fit, then no further request.
    pix_mode = 1;
    f0 = fin_cnt;
    step();
    iENA = 1'b1;
    wait_fin(f0 + 2, 400);
    r0 = req_rises;
    repeat (40) @(negedge iCLOCK);
    #1;
    check("stall_no_req", req_rises, r0);
    check("stall_buffered", exp_q.size(), 32);
    check("stall_fins", fin_cnt, f0 + 2);
    pop_cnt   = 0;
    pop_limit = 16;
    step();
    pix_mode = 3;
    n = 0;
    while (pop_cnt < 16 && n < 200) begin
      @(negedge iCLOCK); #1;
      n++;
    end
    check("release_pops", pop_cnt, 16);
    check("release_no_early_req", req_rises, r0);
    n = 0;
    while (req_rises == r0 && n < 10) begin
      @(negedge iCLOCK); #1;
      n++;
    end
    check("third_req", req_rises, r0 + 1);
    pix_mode = 2;
    wait_fin(f0 + 3, 400);
    step();
    iENA = 1'b0;
    wait_drain(400);

    // Enable dropped during the 5th command of a burst.
    busy_mode = 2;
    pix_mode  = 2;
    lat       = 3;
    f0        = fin_cnt;
    step();
    iENA = 1'b1;
    n = 0;
    while (!(in_burst && b_issued >= 5) && n < 300) begin
      @(negedge iCLOCK); #1;
      n++;
    end
    check("drop_reached_cmd5", b_issued, 5);
    step();
    iENA = 1'b0;
    wait_fin(f0 + 1, 300);
    r0 = req_rises;
    repeat (30) @(negedge iCLOCK);
    #1;
    check("drop_idle", req_rises, r0);
    check("drop_single_fin", fin_cnt, f0 + 1);
    step();
    iENA = 1'b1;
    wait_fin(f0 + 2, 400);
    step();
    iENA = 1'b0;
    busy_mode = 0;
    wait_drain(400);

    // Synchronous reset in DRAIN with 8 words buffered.
    pix_mode = 1;
    lat      = 10;
    f0       = fin_cnt;
    step();
    iENA = 1'b1;
    n = 0;
    while (!(in_burst && b_returned >= 8) && n < 300) begin
      @(negedge iCLOCK); #1;
      n++;
    end
    check("sync_reset_point", b_returned, 8);
    step();
    iRESET_SYNC = 1'b1;
    iENA        = 1'b0;
    exp_q.delete();
    exp_addr    = BASE;
    in_burst    = 1'b0;
    ack_sched   = 1'b0;
    b_issued    = 0;
    b_returned  = 0;
    step();
    iRESET_SYNC = 1'b0;
    @(negedge iCLOCK); #1;
    check_outputs_zero("sync_reset");
    repeat (40) begin
      @(negedge iCLOCK); #1;
      check("late_valid_ignored", oPIX_VALID, 0);
    end
    check("sync_reset_no_fin", fin_cnt, f0);
    check("late_returns_done", ret_q.size(), 0);
    pix_mode = 2;
    lat      = 2;
    step();
    iENA = 1'b1;
    wait_fin(f0 + 1, 300);
    step();
    iENA = 1'b0;
    wait_drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
